// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: feeds operand bits LSB-first to an external 1-bit
// ALU slice, ripples carry/borrow locally and returns the assembled result.
module alu_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  output logic             alu_a,
  output logic             alu_b,
  output logic [2:0]       alu_sel,
  input  logic             alu_result,
  input  logic             alu_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_err,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both
  // high; valid never waits on ready, and DONE holds its outputs until taken.

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, res_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt_q;
  logic             c_q;
  logic             err_q;
  logic             out_valid_q;
  logic             bit_d;
  logic             c_d;

  // Slice output combined with the running carry (add) or borrow (sub).
  always_comb begin
    bit_d = alu_result;
    c_d   = 1'b0;
    case (op_q)
      3'b000: begin
        bit_d = alu_result ^ c_q;
        c_d   = alu_carry | (alu_result & c_q);
      end
      3'b001: begin
        bit_d = alu_result ^ c_q;
        c_d   = alu_carry | (~alu_result & c_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      op_q        <= 3'b000;
      cnt_q       <= '0;
      c_q         <= 1'b0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            op_q  <= in_op;
            cnt_q <= '0;
            c_q   <= 1'b0;
            res_q <= '0;
            err_q <= in_op[2];
            if (in_op[2]) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
            end else begin
              state_q <= S_RUN;
            end
          end
        end
        S_RUN: begin
          // Operands shift down so bit i is always at [0]; result fills from the top.
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          res_q <= {bit_d, res_q[WIDTH-1:1]};
          c_q   <= c_d;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH - 1)) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign alu_a       = (state_q == S_RUN) ? a_q[0] : 1'b0;
  assign alu_b       = (state_q == S_RUN) ? b_q[0] : 1'b0;
  assign alu_sel     = (state_q == S_RUN) ? op_q : 3'b000;
  assign out_valid   = out_valid_q;
  assign out_result  = res_q;
  assign out_carry   = c_q;
  assign out_err     = err_q;
  assign dbg_state_o = state_q;

endmodule
